// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: N-to-1 round-robin stream arbiter feeding a one-entry output register.
// Define RR_STREAM_ARBITER_PKT_LOCK_EN to keep the grant on one channel until its in_last beat.
module rr_stream_arbiter #(
  parameter  int WIDTH    = 8,
  parameter  int SIZE     = 2,
  localparam int CHANNELS = 2**SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic [SIZE-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    outData_q, outData_d;
  logic [SIZE-1:0]     outSel_q, outSel_d;
  logic                outValid_q, outValid_d;
  logic [SIZE-1:0]     ptr_q, ptr_d;

  logic                loadEn;
  logic                accept;
  logic                hasWinner;
  logic [SIZE-1:0]     winner;
  logic [SIZE-1:0]     scanIdx;
  logic [CHANNELS-1:0] candValid;
  logic                winnerLast;

  assign loadEn = !outValid_q || out_ready;
  assign accept = loadEn && hasWinner;

`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  logic                lock_q, lock_d;
  logic [SIZE-1:0]     lockCh_q, lockCh_d;
  logic                outLast_q, outLast_d;

  // While a packet is open only its channel may compete, idle or not.
  assign candValid  = lock_q ? (in_valid & (CHANNELS'(1) << lockCh_q)) : in_valid;
  assign winnerLast = in_last[winner];

  always_comb begin
    lock_d    = lock_q;
    lockCh_d  = lockCh_q;
    outLast_d = outLast_q;
    if (accept) begin
      outLast_d = winnerLast;
      lock_d    = !winnerLast;
      lockCh_d  = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lockCh_q  <= '0;
      outLast_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lockCh_q  <= lockCh_d;
      outLast_q <= outLast_d;
    end
  end

  assign out_last = outLast_q;
`else
  assign candValid  = in_valid;
  assign winnerLast = 1'b1;
`endif

  // Scan starting at the pointer; the SIZE-bit add wraps the search around.
  always_comb begin
    hasWinner = 1'b0;
    winner    = '0;
    scanIdx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      scanIdx = ptr_q + SIZE'(k);
      if (!hasWinner && candValid[scanIdx]) begin
        hasWinner = 1'b1;
        winner    = scanIdx;
      end
    end
  end

  assign in_ready = (!rst && accept) ? (CHANNELS'(1) << winner) : '0;

  always_comb begin
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    outValid_d = outValid_q;
    ptr_d      = ptr_q;
    if (accept) begin
      outData_d  = in_data[winner*WIDTH +: WIDTH];
      outSel_d   = winner;
      outValid_d = 1'b1;
      if (winnerLast) begin
        ptr_d = winner + SIZE'(1);
      end
    end else if (loadEn && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outData_q  <= '0;
      outSel_q   <= '0;
      outValid_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
      outValid_q <= outValid_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_data  = outData_q;
  assign out_sel   = outSel_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: directed vector table, random traffic against a reference model,
// and a packet-lock sequence when RR_STREAM_ARBITER_PKT_LOCK_EN is defined.
module tb_rr_stream_arbiter;

  localparam int WIDTH = 8;
  localparam int SIZE  = 2;
  localparam int CH    = 4;
  localparam logic [31:0] TAB_DATA = 32'h773C_11A5;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        outReady;
    logic [3:0]  last;
    logic [3:0]  expReady;
    logic        expValid;
    logic [7:0]  expData;
    logic [1:0]  expSel;
    logic        expLast;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inData;
  logic [3:0]  inValid;
  logic [3:0]  inReady;
  logic [3:0]  inLast;
  logic [7:0]  outData;
  logic [1:0]  outSel;
  logic        outValid;
  logic        outReady;
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  logic        outLast;
`endif

  int total = 0;
  int bad   = 0;

  bit         mValid;
  logic [7:0] mData;
  int         mSel;
  int         mPtr;
  bit         mLast;
  bit         mLock;
  int         mLockCh;

  vec_t vecs[$];

  rr_stream_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    .in_last   (inLast),
    .out_last  (outLast),
`endif
    .out_data  (outData),
    .out_sel   (outSel),
    .out_valid (outValid),
    .out_ready (outReady)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(logic r, logic [3:0] v, logic [31:0] d, logic o, logic [3:0] l,
                                 logic [3:0] eR, logic eV, logic [7:0] eD, logic [1:0] eS, logic eL);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.outReady = o; x.last = l;
    x.expReady = eR; x.expValid = eV; x.expData = eD; x.expSel = eS; x.expLast = eL;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d,
                               input logic o, input logic [3:0] l);
    rst      = r;
    inValid  = v;
    inData   = d;
    outReady = o;
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    inLast   = l;
`else
    inLast   = 4'hF;
`endif
  endtask

  task automatic runVector(input string tag, input vec_t x);
    applyStimulus(x.rst, x.valid, x.data, x.outReady, x.last);
    #3;
    checkOutput({tag, ".in_ready"}, 32'(inReady), 32'(x.expReady));
    @(posedge clk);
    #1;
    checkOutput({tag, ".out_valid"}, 32'(outValid), 32'(x.expValid));
    checkOutput({tag, ".out_data"}, 32'(outData), 32'(x.expData));
    checkOutput({tag, ".out_sel"}, 32'(outSel), 32'(x.expSel));
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    checkOutput({tag, ".out_last"}, 32'(outLast), 32'(x.expLast));
`endif
  endtask

  // Reference: the first valid candidate going round from the pointer, or -1 if none.
  function automatic int modelWinner(logic [3:0] v);
    if (mLock) return v[mLockCh] ? mLockCh : -1;
    for (int k = 0; k < CH; k++) begin
      if (v[(mPtr + k) % CH]) return (mPtr + k) % CH;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic r, input logic [3:0] v, input logic [31:0] d,
                           input logic o, input logic [3:0] l);
    int w;
    w = modelWinner(v);
    if (r) begin
      mValid = 0; mData = 8'h00; mSel = 0; mPtr = 0; mLast = 0; mLock = 0; mLockCh = 0;
    end else if (!mValid || o) begin
      if (w >= 0) begin
        mData  = d[w*8 +: 8];
        mSel   = w;
        mValid = 1;
        mLast  = l[w];
        if (l[w]) begin
          mLock = 0;
          mPtr  = (w + 1) % CH;
        end else begin
          mLock   = 1;
          mLockCh = w;
        end
      end else if (o) begin
        mValid = 0;
      end
    end
  endtask

  task automatic randomCycles(input int n);
    logic        r, o;
    logic [3:0]  v, l, expR;
    logic [31:0] d;
    int          w;
    for (int i = 0; i < n; i++) begin
      r = (i == 0) || ($urandom_range(0, 99) == 0);
      v = 4'($urandom);
      d = $urandom;
      o = ($urandom_range(0, 3) != 0);
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
      l = 4'($urandom);
`else
      l = 4'hF;
`endif
      applyStimulus(r, v, d, o, l);
      #3;
      w = modelWinner(v);
      expR = (!r && (!mValid || o) && w >= 0) ? 4'(1 << w) : 4'h0;
      checkOutput("rand.in_ready", 32'(inReady), 32'(expR));
      @(posedge clk);
      modelStep(r, v, d, o, l);
      #1;
      checkOutput("rand.out_valid", 32'(outValid), 32'(mValid));
      checkOutput("rand.out_data", 32'(outData), 32'(mData));
      checkOutput("rand.out_sel", 32'(outSel), 32'(mSel));
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
      checkOutput("rand.out_last", 32'(outLast), 32'(mLast));
`endif
    end
  endtask

  initial begin
    mValid = 0; mData = 8'h00; mSel = 0; mPtr = 0; mLast = 0; mLock = 0; mLockCh = 0;
    applyStimulus(1'b1, 4'h0, 32'h0, 1'b1, 4'hF);

    // Reset, single channel, full round-robin wrap, backpressure hold, skip, idle, reset mid-beat.
    vecs.push_back(mkVec(1, 4'hF, TAB_DATA, 1, 4'hF, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(mkVec(0, 4'h1, TAB_DATA, 1, 4'hF, 4'h1, 1, 8'hA5, 0, 1));
    vecs.push_back(mkVec(0, 4'h1, TAB_DATA, 1, 4'hF, 4'h1, 1, 8'hA5, 0, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h2, 1, 8'h11, 1, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h4, 1, 8'h3C, 2, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h8, 1, 8'h77, 3, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h1, 1, 8'hA5, 0, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h2, 1, 8'h11, 1, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h4, 1, 8'h3C, 2, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h8, 1, 8'h77, 3, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h1, 1, 8'hA5, 0, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h2, 1, 8'h11, 1, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h4, 1, 8'h3C, 2, 1));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 0, 4'hF, 4'h0, 1, 8'h3C, 2, 1));
    end
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h8, 1, 8'h77, 3, 1));
    vecs.push_back(mkVec(0, 4'h4, TAB_DATA, 1, 4'hF, 4'h4, 1, 8'h3C, 2, 1));
    vecs.push_back(mkVec(0, 4'h5, TAB_DATA, 1, 4'hF, 4'h1, 1, 8'hA5, 0, 1));
    vecs.push_back(mkVec(0, 4'h5, TAB_DATA, 1, 4'hF, 4'h4, 1, 8'h3C, 2, 1));
    vecs.push_back(mkVec(0, 4'h0, TAB_DATA, 1, 4'hF, 4'h0, 0, 8'h3C, 2, 1));
    vecs.push_back(mkVec(0, 4'h0, TAB_DATA, 0, 4'hF, 4'h0, 0, 8'h3C, 2, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 0, 4'hF, 4'h8, 1, 8'h77, 3, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h1, 1, 8'hA5, 0, 1));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 0, 4'hF, 4'h0, 1, 8'hA5, 0, 1));
    vecs.push_back(mkVec(1, 4'hF, TAB_DATA, 0, 4'hF, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(mkVec(0, 4'hF, TAB_DATA, 1, 4'hF, 4'h1, 1, 8'hA5, 0, 1));

    foreach (vecs[i]) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    randomCycles(3000);

`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    // ch1 opens a packet, keeps the grant while idle, closes it on its third beat, then ch2 follows.
    runVector("lock.reset", mkVec(1, 4'h0, TAB_DATA, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    runVector("lock.beat1", mkVec(0, 4'h2, TAB_DATA, 1, 4'h0, 4'h2, 1, 8'h11, 1, 0));
    runVector("lock.beat2", mkVec(0, 4'h7, TAB_DATA, 1, 4'h0, 4'h2, 1, 8'h11, 1, 0));
    runVector("lock.idle",  mkVec(0, 4'h5, TAB_DATA, 1, 4'h0, 4'h0, 0, 8'h11, 1, 0));
    runVector("lock.beat3", mkVec(0, 4'h7, TAB_DATA, 1, 4'h2, 4'h2, 1, 8'h11, 1, 1));
    runVector("lock.next",  mkVec(0, 4'h5, TAB_DATA, 1, 4'hF, 4'h4, 1, 8'h3C, 2, 1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
